counter_updn_mod: RTL and testbench
===================================

# counter_updn_mod

Parametrised up/down counter with programmable modulus, synchronous load/clear, selectable wrap or saturate mode and terminal-count flags. It replaces the fixed power-of-two up/down counter in the DSM DAC datapath and timing logic, such as the sample-rate dividers, ramp generators and the test-pattern address. An optional prescaler allows slow counting from clk50m without external enable logic.

## Interface
Parameters:
- WIDTH, 8: counter width in bits (≥ 2).
- MAX_VAL, 2**WIDTH-1: highest count value; the count range is 0..MAX_VAL; MAX_VAL ≤ 2**WIDTH-1.
- PRESC_DIV, 4: prescaler division ratio (≥ 1); used only with CNT_UPDN_PRESC_EN.

Ports:
- clk50m  in  1  system clock, 50 MHz.
- rst_n  in  1  reset: asynchronous, active-low; clock clk50m.
- en  in  1  count enable; one step per enabled cycle (or per prescaler tick).
- down  in  1  direction: 1 = decrement, 0 = increment.
- clr  in  1  synchronous clear to 0.
- load  in  1  synchronous load of load_val.
- load_val  in  WIDTH  load value.
- sat  in  1  mode: 1 = saturate at bounds, 0 = wrap modulo MAX_VAL+1.
- cnt  out  WIDTH  current count.
- at_max  out  1  high while cnt == MAX_VAL.
- at_min  out  1  high while cnt == 0.
- tc  out  1  one-cycle pulse: a step wrapped (wrap mode) or hit a bound (saturate mode).

## Operation
- Priority per cycle: clr > load > step > hold.
- clr: cnt ← 0. tc ← 0. Prescaler ← 0.
- load: cnt ← min(load_val, MAX_VAL). tc ← 0. Prescaler ← 0.
- A step occurs when en=1, neither clr nor load is active, and the prescaler tick is true. Without the macro, the tick is always 1.
- Up step, wrap mode: cnt == MAX_VAL → 0 with tc=1; otherwise cnt+1.
- Down step, wrap mode: cnt == 0 → MAX_VAL with tc=1; otherwise cnt−1.
- Up step, saturate mode: cnt == MAX_VAL holds, tc=0. cnt == MAX_VAL−1 → MAX_VAL with tc=1.
- Down step, saturate mode: cnt == 0 holds, tc=0. cnt == 1 → 0 with tc=1.
- The tc pulse marks arrival at or passing of a bound. Staying pinned at a bound produces no tc.
- Any cycle without a step sets tc=0.
- All comparisons use full-width unsigned arithmetic. No intermediate value exceeds WIDTH bits; the wrap is explicit, not a natural overflow.
- at_max and at_min are decoded from the cnt register. They are valid in the same cycle as cnt.
- A change of sat or down takes effect on the next step. There is no stored state besides cnt, tc and the prescaler.

## Timing
- Reset values: cnt=0, tc=0, at_min=1, at_max=0, prescaler=0. Reset is asynchronous and can occur mid-count. Release is synchronous to clk50m.
- Latency is 1 cycle. Inputs sampled at edge N appear on cnt and tc after edge N.
- tc is registered and coincides with the cnt value it refers to. It lasts exactly 1 cycle.
- Back-to-back steps are allowed every cycle. Maximum step rate is 50 MHz without the prescaler.
- clr and load together: clr wins. load and en together: load wins, and the step is lost.

## Configuration
- Macro: CNT_UPDN_PRESC_EN.
- With the macro defined:
  - A prescaler counter of width $clog2(PRESC_DIV) advances on each en cycle.
  - The tick is true when the prescaler equals PRESC_DIV−1 and en=1; the prescaler then returns to 0.
  - cnt therefore steps once per PRESC_DIV enabled cycles.
  - clr and load reset the prescaler.
  - en=0 holds the prescaler.
- Without the macro: no prescaler logic is built, the tick is constant 1, and PRESC_DIV is ignored.

## Structure
- Package counter_pkg holds:
  - the mode typedef (CNT_WRAP, CNT_SAT) used to decode sat;
  - helper function clamp_load(load_val, MAX_VAL).
- Sub-module cnt_prescaler (parameter PRESC_DIV; ports rst_n, clk50m, en, clr, tick). It is instantiated only under CNT_UPDN_PRESC_EN.
- The top level contains the next-state logic, the cnt/tc registers and the at_max/at_min decode.

## Test plan
All scenarios use WIDTH=4, MAX_VAL=9 and no macro unless stated.
- Reset with en=1 mid-count: pull rst_n low asynchronously → cnt=0, tc=0, at_min=1 immediately. After release, the first step gives cnt=1.
- Wrap up: sat=0, load 8, then en=1 up for 3 cycles → cnt 9, 0, 1. tc=1 only while cnt=0; at_max=1 only while cnt=9.
- Wrap down: sat=0, cnt=1, en=1 down for 2 cycles → cnt 0, 9. tc=1 while cnt=9.
- Saturate: sat=1, load 7, en=1 up for 4 cycles → cnt 8, 9, 9, 9. tc=1 only on the first 9. Repeat down from 2 → cnt 1, 0, 0 with tc on the first 0.
- Priority and clamping: load_val=15 with load=1 → cnt=9. clr=1, load=1, en=1 together → cnt=0, tc=0.
- Prescaler (macro defined, PRESC_DIV=4): 12 consecutive en cycles up from 0 → cnt=3. A gap of en=0 cycles does not advance the count. load mid-sequence restarts the 4-cycle grouping.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared types and helpers for the up/down counter family.
package counter_pkg;

  // Widest counter the helper functions support.
  localparam int unsigned CNT_MAX_W = 32;

  // Bound behaviour selected by the sat input.
  typedef enum logic {
    CNT_WRAP = 1'b0,
    CNT_SAT  = 1'b1
  } cnt_mode_e;

  // Limit a load value to the counter's range.
  function automatic logic [CNT_MAX_W-1:0] clamp_load(input logic [CNT_MAX_W-1:0] load_val,
                                                      input logic [CNT_MAX_W-1:0] max_val);
    return (load_val > max_val) ? max_val : load_val;
  endfunction

endpackage

// File: rtl/cnt_prescaler.sv
// Enable prescaler: emits one tick per PRESC_DIV enabled cycles.
// The count holds while en is low; clr restarts the grouping.
module cnt_prescaler #(
  parameter int unsigned PRESC_DIV = 4
) (
  input  logic clk50m,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  // At least one bit so PRESC_DIV=1 still elaborates.
  localparam int unsigned PW = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESC_DIV - 1);

  logic [PW-1:0] presc_q, presc_d;

  // Next prescaler value and tick decode.
  always_comb begin
    presc_d = presc_q;
    tick    = en && (presc_q == LAST);
    if (clr) begin
      presc_d = '0;
    end else if (en) begin
      presc_d = (presc_q == LAST) ? '0 : presc_q + 1'b1;
    end
  end

  // Prescaler register.
  always_ff @(posedge clk50m or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

endmodule

// File: rtl/counter_updn_mod.sv
// Up/down counter with programmable modulus, synchronous clear/load,
// wrap or saturate mode and terminal-count flags.
// Optional prescaler built when CNT_UPDN_PRESC_EN is defined.
module counter_updn_mod
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_VAL   = 2**WIDTH - 1,
  parameter int unsigned PRESC_DIV = 4
) (
  input  logic             clk50m,
  input  logic             rst_n,
  input  logic             en,
  input  logic             down,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             sat,
  output logic [WIDTH-1:0] cnt,
  output logic             at_max,
  output logic             at_min,
  output logic             tc
);

  localparam logic [WIDTH-1:0] MAX = WIDTH'(MAX_VAL);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             tc_q, tc_d;
  logic [WIDTH-1:0] load_clamped;
  logic             tick;
  logic             step;
  cnt_mode_e        mode;

`ifdef CNT_UPDN_PRESC_EN
  cnt_prescaler #(
    .PRESC_DIV (PRESC_DIV)
  ) u_prescaler (
    .clk50m (clk50m),
    .rst_n  (rst_n),
    .en     (en),
    .clr    (clr | load),
    .tick   (tick)
  );
`else
  logic unused_presc;
  assign unused_presc = ^PRESC_DIV;
  assign tick = 1'b1;
`endif

  assign load_clamped = WIDTH'(clamp_load(CNT_MAX_W'(load_val), CNT_MAX_W'(MAX_VAL)));
  assign mode         = sat ? CNT_SAT : CNT_WRAP;
  assign step         = en && tick && !clr && !load;

  // Next count and terminal-count pulse; any non-step cycle clears tc.
  always_comb begin
    cnt_d = cnt_q;
    tc_d  = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = load_clamped;
    end else if (step) begin
      // cnt_q never exceeds MAX, so +1/-1 below never overflow.
      case (mode)
        CNT_WRAP: begin
          if (!down) begin
            if (cnt_q == MAX) begin
              cnt_d = '0;
              tc_d  = 1'b1;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end else begin
            if (cnt_q == '0) begin
              cnt_d = MAX;
              tc_d  = 1'b1;
            end else begin
              cnt_d = cnt_q - 1'b1;
            end
          end
        end
        CNT_SAT: begin
          if (!down) begin
            if (cnt_q != MAX) begin
              cnt_d = cnt_q + 1'b1;
              tc_d  = (cnt_d == MAX);
            end
          end else begin
            if (cnt_q != '0) begin
              cnt_d = cnt_q - 1'b1;
              tc_d  = (cnt_d == '0);
            end
          end
        end
        default: begin
          cnt_d = cnt_q;
        end
      endcase
    end
  end

  // Count and tc registers.
  always_ff @(posedge clk50m or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      tc_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tc_q  <= tc_d;
    end
  end

  // Bound flags decoded straight from the count register.
  always_comb begin
    cnt    = cnt_q;
    tc     = tc_q;
    at_max = (cnt_q == MAX);
    at_min = (cnt_q == '0);
  end

endmodule

// File: tb/tb_counter_updn_mod.sv
// Directed bench for counter_updn_mod with WIDTH=4, MAX_VAL=9.
// Define CNT_UPDN_PRESC_EN to exercise the prescaler build instead.
module tb_counter_updn_mod;

  logic       clk50m = 1'b0;
  logic       rst_n;
  logic       en, down, clr, load, sat;
  logic [3:0] load_val;
  logic [3:0] cnt;
  logic       at_max, at_min, tc;

  int n_tests = 0;
  int n_fail  = 0;

  always #10 clk50m = ~clk50m;

  counter_updn_mod #(
    .WIDTH     (4),
    .MAX_VAL   (9),
    .PRESC_DIV (4)
  ) dut (
    .clk50m   (clk50m),
    .rst_n    (rst_n),
    .en       (en),
    .down     (down),
    .clr      (clr),
    .load     (load),
    .load_val (load_val),
    .sat      (sat),
    .cnt      (cnt),
    .at_max   (at_max),
    .at_min   (at_min),
    .tc       (tc)
  );

  typedef struct {
    logic       clr;
    logic       load;
    logic       en;
    logic       down;
    logic       sat;
    logic [3:0] load_val;
    logic [3:0] exp_cnt;
    logic       exp_tc;
    logic       exp_max;
    logic       exp_min;
  } vec_t;

  vec_t vecs[24];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string name, input int e_cnt, input int e_tc,
                           input int e_max, input int e_min);
    check({name, " cnt"}, int'(cnt), e_cnt);
    check({name, " tc"}, int'(tc), e_tc);
    check({name, " at_max"}, int'(at_max), e_max);
    check({name, " at_min"}, int'(at_min), e_min);
  endtask

  task automatic drive(input logic c, input logic l, input logic e, input logic d,
                       input logic s, input logic [3:0] lv);
    clr = c; load = l; en = e; down = d; sat = s; load_val = lv;
  endtask

  // Apply current inputs across one edge, then sample away from it.
  task automatic tick_clk();
    @(posedge clk50m);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 4'd0);
    #25;
    check_all("reset", 0, 0, 0, 1);
    @(negedge clk50m);
    rst_n = 1'b1;

`ifndef CNT_UPDN_PRESC_EN
    //             clr load en down sat lv  cnt tc max min
    vecs[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd8,  4'd8, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0,  4'd9, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0,  4'd0, 1'b1, 1'b0, 1'b1};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0,  4'd1, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0,  4'd0, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0,  4'd9, 1'b1, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0,  4'd9, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd7,  4'd7, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0,  4'd8, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0,  4'd9, 1'b1, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0,  4'd9, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0,  4'd9, 1'b0, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd2,  4'd2, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd0,  4'd1, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd0,  4'd0, 1'b1, 1'b0, 1'b1};
    vecs[15] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd0,  4'd0, 1'b0, 1'b0, 1'b1};
    vecs[16] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd15, 4'd9, 1'b0, 1'b1, 1'b0};
    vecs[17] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd5,  4'd0, 1'b0, 1'b0, 1'b1};
    vecs[18] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd5,  4'd5, 1'b0, 1'b0, 1'b0};
    vecs[19] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0,  4'd6, 1'b0, 1'b0, 1'b0};
    vecs[20] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0,  4'd0, 1'b0, 1'b0, 1'b1};
    vecs[21] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd9,  4'd9, 1'b0, 1'b1, 1'b0};
    // sat switched off takes effect on this step: wraps with tc.
    vecs[22] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0,  4'd0, 1'b1, 1'b0, 1'b1};
    vecs[23] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd0,  4'd0, 1'b0, 1'b0, 1'b1};

    // Reset mid-count: count a few steps, then assert rst_n between edges.
    drive(0, 0, 1, 0, 0, 4'd0);
    tick_clk();
    tick_clk();
    tick_clk();
    check_all("pre-reset count", 3, 0, 0, 0);
    #3;
    rst_n = 1'b0;
    #1;
    check_all("async reset", 0, 0, 0, 1);
    @(negedge clk50m);
    rst_n = 1'b1;
    tick_clk();
    check_all("first step after reset", 1, 0, 0, 0);

    for (int i = 0; i < 24; i++) begin
      drive(vecs[i].clr, vecs[i].load, vecs[i].en, vecs[i].down, vecs[i].sat,
            vecs[i].load_val);
      tick_clk();
      check_all($sformatf("vec%0d", i), int'(vecs[i].exp_cnt), int'(vecs[i].exp_tc),
                int'(vecs[i].exp_max), int'(vecs[i].exp_min));
    end
`else
    // Prescaler build: one step per 4 enabled cycles.
    drive(0, 0, 1, 0, 0, 4'd0);
    for (int i = 1; i <= 12; i++) begin
      tick_clk();
      check($sformatf("presc cyc%0d cnt", i), int'(cnt), i / 4);
    end
    drive(0, 0, 0, 0, 0, 4'd0);
    for (int i = 0; i < 5; i++) tick_clk();
    check("presc gap cnt", int'(cnt), 3);
    // Two enabled cycles, then load restarts the grouping.
    drive(0, 0, 1, 0, 0, 4'd0);
    tick_clk();
    tick_clk();
    check("presc partial cnt", int'(cnt), 3);
    drive(0, 1, 1, 0, 0, 4'd0);
    tick_clk();
    check("presc load cnt", int'(cnt), 0);
    drive(0, 0, 1, 0, 0, 4'd0);
    tick_clk();
    tick_clk();
    tick_clk();
    check("presc after load 3 cyc", int'(cnt), 0);
    tick_clk();
    check("presc after load 4 cyc", int'(cnt), 1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
